// File: rtl/serial_pkg.sv
// Shared types and constants for the serial datapath blocks.
package serial_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Frame length in bits: data word plus an optional trailing parity bit.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry valid/ready holding buffer; pop frees the entry in the same cycle a new word may enter.
module piso_hold_buf
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  assign in_ready = !full || pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with zero-gap streaming through a one-word hold buffer.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int unsigned FL = frame_len(WIDTH, PARITY_EN);
  localparam int unsigned CW = $clog2(FL);

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             hold_move;
  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [FL-1:0]    sreg;
  logic [FL-1:0]    load_word;
  logic [FL-1:0]    shifted;
  logic             at_last;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pop     (hold_move),
    .data    (hold_data),
    .full    (hold_full)
  );

  assign at_last   = (bit_cnt == CW'(FL - 1));
  assign hold_move = hold_full && ((state == IDLE) || at_last);

  // Parity sits after the data bits in transmit order, so its slot depends on shift direction.
  always_comb begin
    load_word = '0;
`ifdef PISO_PARITY_EN
    load_word = MSB_FIRST ? {hold_data, ^hold_data} : {^hold_data, hold_data};
`else
    load_word = hold_data;
`endif
  end

  assign shifted = MSB_FIRST ? {sreg[FL-2:0], 1'b0} : {1'b0, sreg[FL-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_move) begin
            sreg    <= load_word;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (hold_move) begin
            sreg    <= load_word;
            bit_cnt <= '0;
          end else begin
            sreg    <= shifted;
            bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
            if (at_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign so_valid = (state == SHIFT);
  assign so       = so_valid && (MSB_FIRST ? sreg[FL-1] : sreg[0]);
  assign so_last  = so_valid && at_last;
  assign busy     = so_valid || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer: both bit orders checked against a frame-schedule model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic m_ready, m_so, m_sov, m_last, m_busy;
  logic l_ready, l_so, l_sov, l_last, l_busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_ready),
    .so(m_so), .so_valid(m_sov), .so_last(m_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
    .so(l_so), .so_valid(l_sov), .so_last(l_last), .busy(l_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: every accepted word owns FL output slots, keyed by the edge after which each bit shows.
  bit exp_msb[int];
  bit exp_lsb[int];
  bit exp_last[int];
  bit have_word = 1'b0;
  int last_start = 0;
  int start_e = 0;
  bit took = 1'b0;
  bit v_now = 1'b0;
  bit par = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Ready at edge e unless a queued word is still waiting to start after e.
  function automatic bit ready_at(input int e);
    return !(have_word && last_start > e);
  endfunction

  always @(posedge clk) begin
    cyc  = cyc + 1;
    took = 1'b0;
    if (rst) begin
      for (int k = cyc; k < cyc + 3 * FL; k++) begin
        if (exp_msb.exists(k)) begin
          exp_msb.delete(k);
          exp_lsb.delete(k);
          exp_last.delete(k);
        end
      end
      have_word = 1'b0;
    end else if (in_valid && ready_at(cyc)) begin
      start_e = (have_word && last_start + FL > cyc + 1) ? last_start + FL : cyc + 1;
      par = ^in_data;
      for (int i = 0; i < FL; i++) begin
        exp_msb[start_e + i]  = (i < W) ? in_data[W-1-i] : par;
        exp_lsb[start_e + i]  = (i < W) ? in_data[i] : par;
        exp_last[start_e + i] = (i == FL - 1);
      end
      have_word  = 1'b1;
      last_start = start_e;
      took       = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      v_now = exp_msb.exists(cyc);
      check("so_valid_msb", m_sov, v_now);
      check("so_valid_lsb", l_sov, v_now);
      check("so_msb", m_so, v_now ? exp_msb[cyc] : 1'b0);
      check("so_lsb", l_so, v_now ? exp_lsb[cyc] : 1'b0);
      check("so_last_msb", m_last, v_now ? exp_last[cyc] : 1'b0);
      check("so_last_lsb", l_last, v_now ? exp_last[cyc] : 1'b0);
      check("busy_msb", m_busy, v_now || (have_word && last_start > cyc));
      check("busy_lsb", l_busy, v_now || (have_word && last_start > cyc));
      check("in_ready_msb", m_ready, ready_at(cyc + 1));
      check("in_ready_lsb", l_ready, ready_at(cyc + 1));
    end
  end

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 4 * FL; n++) begin
      @(posedge clk);
      #2;
      if (took) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    send(4'b1011); idle(2 * FL);
    send(4'hA); send(4'h5); idle(3 * FL);
    send(4'h9); send(4'h6); send(4'hC); idle(4 * FL);
    send(4'b0001); idle(2 * FL);
    send(4'b0111); idle(2 * FL);
    send(4'b0011); idle(2 * FL);

    // Reset lands while the second bit of 4'hF is on the line.
    send(4'hF);
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(4'h3); idle(2 * FL);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = W'($urandom);
      end
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    idle(3 * FL + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
